// File: rtl/logic_processor_pkg.sv
// Shared types and widths for the logic processor input conditioner.
package logic_processor_pkg;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_t;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned D_W         = 4;
    localparam int unsigned F_W         = 3;
    localparam int unsigned R_W         = 2;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one active-low button, debounces it and emits a registered
// one-cycle pulse on each accepted press.
module button_debouncer
    import logic_processor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q;
    logic                   rise_q;
    db_state_t              sample;

    assign sample = sync_q[SYNC_STAGES-1] ? RELEASED : PRESSED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level;
            rise_q  <= level & ~level_q;
        end
    end

    // Counter clears on toggle, so it never exceeds DEBOUNCE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sample != state_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                state_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        level = (state_q == PRESSED);
        rise  = rise_q;
    end

endmodule

// File: rtl/logic_processor_input_conditioner.sv
// Board front end: synchronises switches, debounces buttons, interlocks loads
// against Execute and freezes F/R while Execute is held.
module logic_processor_input_conditioner
    import logic_processor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic           CLK,
    input  logic           CLRN,
    input  logic           KEY_Load_A_N,
    input  logic           KEY_Load_B_N,
    input  logic           KEY_Execute_N,
    input  logic [D_W-1:0] SW_D,
    input  logic [F_W-1:0] SW_F,
    input  logic [R_W-1:0] SW_R,
    output logic [D_W-1:0] D,
    output logic [F_W-1:0] F,
    output logic [R_W-1:0] R,
    output logic           Load_A,
    output logic           Load_B,
    output logic           Execute
);

    logic rise_a, rise_b, exec_level;
    logic unused_level_a, unused_level_b, unused_rise_exec;

    logic [SYNC_STAGES-1:0][D_W-1:0] sw_d_sync;
    logic [SYNC_STAGES-1:0][F_W-1:0] sw_f_sync;
    logic [SYNC_STAGES-1:0][R_W-1:0] sw_r_sync;
    logic [F_W-1:0]                  f_q;
    logic [R_W-1:0]                  r_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load_a (
        .clk(CLK), .rst_n(CLRN), .key_n(KEY_Load_A_N),
        .level(unused_level_a), .rise(rise_a)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load_b (
        .clk(CLK), .rst_n(CLRN), .key_n(KEY_Load_B_N),
        .level(unused_level_b), .rise(rise_b)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_execute (
        .clk(CLK), .rst_n(CLRN), .key_n(KEY_Execute_N),
        .level(exec_level), .rise(unused_rise_exec)
    );

    // F/R load only while Execute was low before this edge, so the rising
    // edge captures and the falling edge still holds for one more cycle.
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            sw_d_sync <= '0;
            sw_f_sync <= '0;
            sw_r_sync <= '0;
            f_q       <= '0;
            r_q       <= '0;
        end else begin
            sw_d_sync <= {sw_d_sync[SYNC_STAGES-2:0], SW_D};
            sw_f_sync <= {sw_f_sync[SYNC_STAGES-2:0], SW_F};
            sw_r_sync <= {sw_r_sync[SYNC_STAGES-2:0], SW_R};
            if (!exec_level) begin
                f_q <= sw_f_sync[SYNC_STAGES-1];
                r_q <= sw_r_sync[SYNC_STAGES-1];
            end
        end
    end

    always_comb begin
        D       = sw_d_sync[SYNC_STAGES-1];
        F       = f_q;
        R       = r_q;
        Execute = exec_level;
        Load_A  = rise_a & ~exec_level;
        Load_B  = rise_b & ~exec_level;
    end

endmodule
